// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types and the arbiter state encoding.
package lc3b_types;
    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_block;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } lc3b_arb_state;

    // Request bundle routed through the select mux: {read, write, address, wdata}
    localparam int REQ_W = 2 + $bits(lc3b_word) + $bits(lc3b_block);
endpackage

// File: rtl/cache_arbiter_mux2.sv
// Generic parameterised 2:1 mux; sel = 1 picks b.
module cache_arbiter_mux2 #(
    parameter int WIDTH = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? b : a;
endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache line fills and D-cache fills/writebacks onto one memory port.
// state   | meaning
// IDLE    | no owner; memory request lines low, pmem_resp ignored
// SERVE_I | I-cache owns the port until pmem_resp
// SERVE_D | D-cache owns the port until pmem_resp
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ROUND_ROBIN = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_pmem_read,
    input  logic [15:0]  i_pmem_address,
    output logic [127:0] i_pmem_rdata,
    output logic         i_pmem_resp,
    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [15:0]  d_pmem_address,
    input  logic [127:0] d_pmem_wdata,
    output logic [127:0] d_pmem_rdata,
    output logic         d_pmem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);
    lc3b_arb_state state, next_state;
    logic          last_grant_d;
    logic          i_req, d_req, d_wins;
    logic [REQ_W-1:0] sel_req;
    logic          sel_read, sel_write;

    assign i_req  = i_pmem_read;
    assign d_req  = d_pmem_read | d_pmem_write;
    assign d_wins = (ROUND_ROBIN != 0) ? ~last_grant_d : 1'b1;

    cache_arbiter_mux2 #(.WIDTH(REQ_W)) u_req_mux (
        .sel (state == SERVE_D),
        .a   ({i_pmem_read, 1'b0, i_pmem_address, 128'd0}),
        .b   ({d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata}),
        .y   (sel_req)
    );

    assign {sel_read, sel_write, pmem_address, pmem_wdata} = sel_req;

    // Read data is broadcast; only the per-requester resp marks it valid.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state != IDLE)
                last_grant_d <= (next_state == SERVE_D);
        end
    end

    always_comb begin
        next_state  = state;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || d_wins))
                    next_state = SERVE_D;
                else if (i_req)
                    next_state = SERVE_I;
            end
            SERVE_I: begin
                pmem_read   = sel_read;
                i_pmem_resp = pmem_resp;
                if (pmem_resp)
                    next_state = IDLE;
            end
            SERVE_D: begin
                pmem_read   = sel_read;
                pmem_write  = sel_write;
                d_pmem_resp = pmem_resp;
                if (pmem_resp)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench: per-cycle vector table on the fixed-priority arbiter, then reset and round-robin sequences.
module tb_cache_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic         d_pmem_read, d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    logic [127:0] i_rdata0, d_rdata0, i_rdata1, d_rdata1;
    logic         i_resp0, d_resp0, i_resp1, d_resp1;
    logic         p_read0, p_write0, p_read1, p_write1;
    logic [15:0]  p_addr0, p_addr1;
    logic [127:0] p_wdata0, p_wdata1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_arbiter #(.ROUND_ROBIN(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_rdata0), .i_pmem_resp(i_resp0),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_rdata0), .d_pmem_resp(d_resp0),
        .pmem_read(p_read0), .pmem_write(p_write0),
        .pmem_address(p_addr0), .pmem_wdata(p_wdata0),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    cache_arbiter #(.ROUND_ROBIN(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_rdata1), .i_pmem_resp(i_resp1),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_rdata1), .d_pmem_resp(d_resp1),
        .pmem_read(p_read1), .pmem_write(p_write1),
        .pmem_address(p_addr1), .pmem_wdata(p_wdata1),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    typedef struct {
        logic         ir;
        logic [15:0]  ia;
        logic         dr, dw;
        logic [15:0]  da;
        logic [127:0] dwd;
        logic         presp;
        logic         e_rd, e_wr;
        logic [15:0]  e_addr;
        logic [127:0] e_wd;
        logic         e_iresp, e_dresp;
    } vec_t;

    vec_t tv[$];

    localparam logic [127:0] W1 = 128'hDEADBEEF_01234567_89ABCDEF_0F0FF0F0;
    localparam logic [127:0] W2 = 128'h11112222_33334444_55556666_77778888;

    function automatic vec_t mk(logic ir, logic [15:0] ia, logic dr, logic dw,
                                logic [15:0] da, logic [127:0] dwd, logic presp,
                                logic e_rd, logic e_wr, logic [15:0] e_addr,
                                logic [127:0] e_wd, logic e_iresp, logic e_dresp);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
        v.presp = presp; v.e_rd = e_rd; v.e_wr = e_wr; v.e_addr = e_addr;
        v.e_wd = e_wd; v.e_iresp = e_iresp; v.e_dresp = e_dresp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                         input logic [15:0] da, input logic [127:0] dwd, input logic presp);
        i_pmem_read = ir; i_pmem_address = ia;
        d_pmem_read = dr; d_pmem_write = dw;
        d_pmem_address = da; d_pmem_wdata = dwd;
        pmem_resp = presp;
    endtask

    initial begin
        logic [255:0] act, exp;
        logic         found;
        rst = 1'b1;
        drive(0, 16'h0, 0, 0, 16'h0, 128'd0, 0);
        pmem_rdata = '0;

        // ir ia       dr dw da       dwd  resp | rd wr addr     wdata   iresp dresp
        tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0,   0, 0, 16'h0000, 0,  0, 0));
        tv.push_back(mk(1, 16'h1230, 0, 0, 16'h0000, 0,  0,   0, 0, 16'h0000, 0,  0, 0));
        tv.push_back(mk(1, 16'h1230, 0, 0, 16'h0000, 0,  0,   1, 0, 16'h1230, 0,  0, 0));
        tv.push_back(mk(1, 16'h1230, 0, 0, 16'h0000, 0,  0,   1, 0, 16'h1230, 0,  0, 0));
        tv.push_back(mk(1, 16'h1230, 0, 0, 16'h0000, 0,  1,   1, 0, 16'h1230, 0,  1, 0));
        tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0,   0, 0, 16'h0000, 0,  0, 0));
        tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0,  1,   0, 0, 16'h0000, 0,  0, 0));
        tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0,   0, 0, 16'h0000, 0,  0, 0));
        tv.push_back(mk(1, 16'h0040, 0, 1, 16'h8000, W1, 0,   0, 0, 16'h0000, 0,  0, 0));
        tv.push_back(mk(1, 16'h0040, 0, 1, 16'h8000, W1, 0,   0, 1, 16'h8000, W1, 0, 0));
        tv.push_back(mk(1, 16'h0040, 0, 1, 16'h8000, W1, 1,   0, 1, 16'h8000, W1, 0, 1));
        tv.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 0,  0,   0, 0, 16'h0000, 0,  0, 0));
        tv.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 0,  0,   1, 0, 16'h0040, 0,  0, 0));
        tv.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 0,  1,   1, 0, 16'h0040, 0,  1, 0));
        tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0,   0, 0, 16'h0000, 0,  0, 0));
        tv.push_back(mk(0, 16'h0000, 1, 0, 16'h2000, 0,  0,   0, 0, 16'h0000, 0,  0, 0));
        tv.push_back(mk(0, 16'h0000, 1, 0, 16'h2000, 0,  0,   1, 0, 16'h2000, 0,  0, 0));
        tv.push_back(mk(0, 16'h0000, 0, 0, 16'h2000, 0,  0,   0, 0, 16'h0000, 0,  0, 0));
        tv.push_back(mk(0, 16'h0000, 0, 0, 16'h2000, 0,  1,   0, 0, 16'h0000, 0,  0, 1));
        tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0,  1,   0, 0, 16'h0000, 0,  0, 0));
        tv.push_back(mk(0, 16'h0000, 1, 1, 16'h3000, W2, 0,   0, 0, 16'h0000, 0,  0, 0));
        tv.push_back(mk(0, 16'h0000, 1, 1, 16'h3000, W2, 0,   1, 1, 16'h3000, W2, 0, 0));
        tv.push_back(mk(0, 16'h0000, 1, 1, 16'h3000, W2, 1,   1, 1, 16'h3000, W2, 0, 1));
        tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0,  0,   0, 0, 16'h0000, 0,  0, 0));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < tv.size(); k++) begin
            drive(tv[k].ir, tv[k].ia, tv[k].dr, tv[k].dw, tv[k].da, tv[k].dwd, tv[k].presp);
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            act = '0; exp = '0;
            act[147:144] = {p_read0, p_write0, i_resp0, d_resp0};
            exp[147:144] = {tv[k].e_rd, tv[k].e_wr, tv[k].e_iresp, tv[k].e_dresp};
            if (tv[k].e_rd || tv[k].e_wr) begin
                act[143:0] = {p_addr0, p_wdata0};
                exp[143:0] = {tv[k].e_addr, tv[k].e_wd};
            end
            chk($sformatf("vec%0d", k), act, exp);
            chk($sformatf("vec%0d_rdata", k), {i_rdata0, d_rdata0}, {pmem_rdata, pmem_rdata});
            @(posedge clk);
            #1;
        end

        // Reset while the D-cache writeback is in flight.
        drive(0, 16'h0, 0, 1, 16'h4000, W1, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pre_write", {255'd0, p_write0}, 256'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 16'h0, 0, 0, 16'h4000, W1, 1);
        @(negedge clk);
        chk("rst_mid", {252'd0, p_read0, p_write0, i_resp0, d_resp0}, 256'd0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("rst_after", {252'd0, p_read0, p_write0, i_resp0, d_resp0}, 256'd0);
        @(posedge clk); #1;

        // Continuous contention: dut1 alternates D,I,D,I; dut0 always grants D.
        drive(1, 16'h1111, 1, 0, 16'h2222, 128'd0, 0);
        for (int t = 0; t < 4; t++) begin
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge clk);
                if (p_read1) found = 1'b1;
                else begin @(posedge clk); #1; end
            end
            if (!found) begin
                errors++; checks++;
                $display("FAIL rr_grant%0d: no grant within 8 cycles, expected one", t);
            end else begin
                chk($sformatf("rr_addr%0d", t), {240'd0, p_addr1},
                    {240'd0, (t % 2 == 0) ? 16'h2222 : 16'h1111});
                chk($sformatf("fp_addr%0d", t), {240'd0, p_addr0}, {240'd0, 16'h2222});
                pmem_resp = 1'b1;
                #1;
                chk($sformatf("rr_resp%0d", t), {254'd0, i_resp1, d_resp1},
                    (t % 2 == 0) ? 256'd1 : 256'd2);
                @(posedge clk); #1;
                pmem_resp = 1'b0;
                @(negedge clk);
                chk($sformatf("rr_dead%0d", t), {254'd0, p_read1, p_read0}, 256'd0);
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
